// File: rtl/spi_master_stream.sv
// SPI mode-0 master: streams bytes from an external slave to a valid/ready consumer
// until an EOT byte arrives, and sends a 3-byte marker/hi/lo result frame.
module spi_master_stream #(
  parameter int         CLK_DIV     = 2,
  parameter logic [7:0] EOT_BYTE    = 8'h04,
  parameter logic [7:0] MARKER_BYTE = 8'h50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_start,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_eot,
  output logic [15:0] rx_count,
  input  logic        wr_start,
  input  logic [15:0] wr_data,
  output logic        wr_done,
  output logic        busy,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_ss_out,
  input  logic        spi_miso
);

  localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SETUP, RD_HI, RD_LO, RD_HOLD, WR_SETUP, WR_HI, WR_LO, FINISH
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] div_cnt_reg;
  logic [4:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic [23:0]   frame_reg;
  logic [7:0]    rx_byte_reg;
  logic [15:0]   rx_count_reg;
  logic          rx_valid_reg, rx_eot_reg, wr_done_reg;
  logic          sclk_reg, mosi_reg, ss_reg;
  logic          div_end;

  assign div_end = (div_cnt_reg == DIV_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        // A simultaneous read request takes priority; the write is dropped.
        if (rd_start)      state_next = RD_SETUP;
        else if (wr_start) state_next = WR_SETUP;
      end
      RD_SETUP: if (div_end) state_next = RD_HI;
      RD_HI:    if (div_end) state_next = RD_LO;
      RD_LO: begin
        if (div_end) begin
          if (bit_cnt_reg == 5'd7)
            state_next = (shift_reg == EOT_BYTE) ? FINISH : RD_HOLD;
          else
            state_next = RD_HI;
        end
      end
      RD_HOLD:  if (rx_ready) state_next = RD_SETUP;
      WR_SETUP: if (div_end) state_next = WR_HI;
      WR_HI:    if (div_end) state_next = WR_LO;
      WR_LO: begin
        if (div_end) state_next = (bit_cnt_reg == 5'd23) ? FINISH : WR_HI;
      end
      FINISH:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      div_cnt_reg  <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      frame_reg    <= '0;
      rx_byte_reg  <= '0;
      rx_count_reg <= '0;
      rx_valid_reg <= 1'b0;
      rx_eot_reg   <= 1'b0;
      wr_done_reg  <= 1'b0;
      sclk_reg     <= 1'b0;
      mosi_reg     <= 1'b0;
      ss_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      div_cnt_reg  <= (state_next != state_reg) ? '0 : div_cnt_reg + CW'(1);
      sclk_reg     <= (state_next == RD_HI) || (state_next == WR_HI);
      ss_reg       <= (state_next == IDLE) || (state_next == FINISH);
      rx_valid_reg <= (state_next == RD_HOLD);
      rx_eot_reg   <= (state_reg == RD_LO) && (state_next == FINISH);
      wr_done_reg  <= (state_reg == WR_LO) && (state_next == FINISH);

      if (state_next == RD_SETUP || state_next == WR_SETUP)
        bit_cnt_reg <= '0;
      else if ((state_reg == RD_LO || state_reg == WR_LO) && div_end)
        bit_cnt_reg <= bit_cnt_reg + 5'd1;

      // MISO is captured on the edge that raises SCLK.
      if (state_next == RD_HI && state_reg != RD_HI)
        shift_reg <= {shift_reg[6:0], spi_miso};

      if (state_next == RD_HOLD && state_reg != RD_HOLD)
        rx_byte_reg <= shift_reg;

      if (state_reg == IDLE && rd_start)
        rx_count_reg <= '0;
      else if (state_reg == RD_HOLD && rx_ready)
        rx_count_reg <= rx_count_reg + 16'd1;

      // MOSI advances on the edge that drops SCLK; zero fill leaves it low at the end.
      if (state_reg == IDLE && state_next == WR_SETUP) begin
        frame_reg <= {MARKER_BYTE, wr_data};
        mosi_reg  <= MARKER_BYTE[7];
      end else if (state_reg == WR_HI && state_next == WR_LO) begin
        frame_reg <= {frame_reg[22:0], 1'b0};
        mosi_reg  <= frame_reg[22];
      end else if (state_next == FINISH || state_next == IDLE) begin
        mosi_reg  <= 1'b0;
      end
    end
  end

  assign rx_byte    = rx_byte_reg;
  assign rx_valid   = rx_valid_reg;
  assign rx_eot     = rx_eot_reg;
  assign rx_count   = rx_count_reg;
  assign wr_done    = wr_done_reg;
  assign busy       = (state_reg != IDLE);
  assign spi_sclk   = sclk_reg;
  assign spi_mosi   = mosi_reg;
  assign spi_ss_out = ss_reg;

endmodule

// File: tb/tb_spi_master_stream.sv
// Bench for spi_master_stream: SPI slave model, directed reads/writes, and a
// scoreboard monitor that checks every accepted rx byte against a queue.
module tb_spi_master_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_start;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_eot;
  logic [15:0] rx_count;
  logic        wr_start;
  logic [15:0] wr_data;
  logic        wr_done;
  logic        busy;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_ss_out;
  logic        spi_miso;

  always #5 clk = ~clk;

  spi_master_stream #(.CLK_DIV(2), .EOT_BYTE(8'h04), .MARKER_BYTE(8'h50)) dut (
    .clk(clk), .rst(rst), .rd_start(rd_start),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_eot(rx_eot), .rx_count(rx_count),
    .wr_start(wr_start), .wr_data(wr_data), .wr_done(wr_done), .busy(busy),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_out(spi_ss_out),
    .spi_miso(spi_miso)
  );

  // Slave model: a bit stream that advances on SCLK falling edges while selected.
  logic [7:0]  slave_mem [0:3];
  logic [7:0]  slave_nbits = 8'd0;
  logic [7:0]  bit_idx = 8'd0;
  logic [23:0] cap = 24'd0;
  int          sclk_rises = 0;

  always @(posedge spi_ss_out or negedge spi_sclk) begin
    if (spi_ss_out) bit_idx = 8'd0;
    else            bit_idx = bit_idx + 8'd1;
  end

  assign spi_miso = (bit_idx < slave_nbits) ? slave_mem[bit_idx[4:3]][3'd7 - bit_idx[2:0]] : 1'b0;

  always @(posedge spi_sclk) begin
    sclk_rises++;
    if (!spi_ss_out) cap = {cap[22:0], spi_mosi};
  end

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q [$];
  int         eot_cnt = 0;
  int         done_cnt = 0;
  int         valid_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic load_slave(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] nbytes);
    slave_mem[0] = b0;
    slave_mem[1] = b1;
    slave_mem[2] = b2;
    slave_mem[3] = 8'h00;
    slave_nbits  = nbytes << 3;
  endtask

  task automatic pulse_rd();
    @(negedge clk); rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0;
    #2;
  endtask

  task automatic wait_ss_high(output int n_low, output int ones);
    n_low = 0;
    ones  = 0;
    while (spi_ss_out == 1'b0 && n_low < 2000) begin
      n_low++;
      if (spi_mosi) ones++;
      @(negedge clk); #2;
    end
  endtask

  task automatic run_write(input logic [15:0] d, output int n_done, output int pulses);
    n_done = -1;
    pulses = 0;
    @(negedge clk); wr_start = 1'b1; wr_data = d;
    for (int k = 1; k <= 150; k++) begin
      @(negedge clk);
      if (k == 1) wr_start = 1'b0;
      #2;
      if (wr_done) begin
        pulses++;
        if (n_done < 0) n_done = k;
      end
    end
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk); #2;
          if (!rst) begin
            if (rx_valid && rx_ready) begin
              if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL rx_byte_extra: got %0h expected none", rx_byte);
              end else begin
                chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
              end
            end
            if (rx_eot)   eot_cnt++;
            if (wr_done)  done_cnt++;
            if (rx_valid) valid_cyc++;
          end
        end
      end
      begin : stimulus
        int n_low, ones, n_done, pulses, e0, d0, v0, r0, stable, nw;
        rst = 1'b1; rd_start = 1'b0; wr_start = 1'b0; wr_data = 16'd0; rx_ready = 1'b1;
        load_slave(8'h00, 8'h00, 8'h00, 8'd0);
        repeat (3) @(negedge clk);
        #2;
        chk("reset_ss",       {31'd0, spi_ss_out}, 32'd1);
        chk("reset_sclk",     {31'd0, spi_sclk},   32'd0);
        chk("reset_mosi",     {31'd0, spi_mosi},   32'd0);
        chk("reset_rx_valid", {31'd0, rx_valid},   32'd0);
        chk("reset_rx_byte",  {24'd0, rx_byte},    32'd0);
        chk("reset_rx_eot",   {31'd0, rx_eot},     32'd0);
        chk("reset_rx_count", {16'd0, rx_count},   32'd0);
        chk("reset_wr_done",  {31'd0, wr_done},    32'd0);
        chk("reset_busy",     {31'd0, busy},       32'd0);
        @(negedge clk); rst = 1'b0;

        // Stream "AB" + EOT with rx_ready high: SS low 3*(17*2+1)-1 = 104 cycles.
        load_slave(8'h41, 8'h42, 8'h04, 8'd3);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        e0 = eot_cnt;
        pulse_rd();
        wait_ss_high(n_low, ones);
        chk("read_ss_low_cycles", n_low, 32'd104);
        chk("read_mosi_ones", ones, 32'd0);
        chk("read_busy_in_finish", {31'd0, busy}, 32'd1);
        @(negedge clk); #2;
        chk("read_busy_after", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        chk("read_rx_count", {16'd0, rx_count}, 32'd2);
        chk("read_eot_pulses", eot_cnt - e0, 32'd1);
        chk("read_queue_drained", exp_q.size(), 32'd0);

        // Backpressure: hold rx_ready low for 20 cycles on the first byte.
        load_slave(8'h41, 8'h42, 8'h04, 8'd3);
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        rx_ready = 1'b0;
        pulse_rd();
        nw = 0;
        while (!rx_valid && nw < 200) begin @(negedge clk); #2; nw++; end
        chk("bp_rx_valid_rises", {31'd0, rx_valid}, 32'd1);
        r0 = sclk_rises;
        stable = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk); #2;
          if (rx_valid && rx_byte == 8'h41 && !spi_sclk && !spi_ss_out) stable++;
        end
        chk("bp_stall_stable_cycles", stable, 32'd20);
        chk("bp_no_sclk_edges", sclk_rises - r0, 32'd0);
        @(negedge clk); rx_ready = 1'b1;
        #2;
        wait_ss_high(n_low, ones);
        repeat (3) @(negedge clk);
        #2;
        chk("bp_rx_count", {16'd0, rx_count}, 32'd2);
        chk("bp_queue_drained", exp_q.size(), 32'd0);

        // EOT as the very first byte.
        load_slave(8'h04, 8'h00, 8'h00, 8'd1);
        e0 = eot_cnt; v0 = valid_cyc;
        pulse_rd();
        wait_ss_high(n_low, ones);
        chk("eot_first_ss_low_cycles", n_low, 32'd34);
        repeat (2) @(negedge clk);
        #2;
        chk("eot_first_no_valid", valid_cyc - v0, 32'd0);
        chk("eot_first_eot_pulses", eot_cnt - e0, 32'd1);
        chk("eot_first_rx_count", {16'd0, rx_count}, 32'd0);

        // Result frame 'P', 8'h12, 8'h34; wr_done at cycle 1+49*2.
        run_write(16'h1234, n_done, pulses);
        chk("write_capture", {8'd0, cap}, 32'h00501234);
        chk("write_done_cycle", n_done, 32'd99);
        chk("write_done_pulses", pulses, 32'd1);
        chk("write_idle_after", {31'd0, busy}, 32'd0);

        // Reset after the 3rd SCLK rise of a read.
        load_slave(8'hA5, 8'h04, 8'h00, 8'd2);
        r0 = sclk_rises;
        pulse_rd();
        nw = 0;
        while (sclk_rises - r0 < 3 && nw < 200) begin @(negedge clk); #2; nw++; end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #2;
        chk("rst_mid_ss",   {31'd0, spi_ss_out}, 32'd1);
        chk("rst_mid_sclk", {31'd0, spi_sclk},   32'd0);
        chk("rst_mid_busy", {31'd0, busy},       32'd0);
        chk("rst_mid_valid", {31'd0, rx_valid},  32'd0);
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(8'hA5);
        pulse_rd();
        wait_ss_high(n_low, ones);
        chk("rst_reread_ss_low_cycles", n_low, 32'd69);
        repeat (2) @(negedge clk);
        #2;
        chk("rst_reread_rx_count", {16'd0, rx_count}, 32'd1);
        chk("rst_reread_queue_drained", exp_q.size(), 32'd0);

        // wr_start during a read is ignored.
        load_slave(8'h33, 8'h04, 8'h00, 8'd2);
        exp_q.push_back(8'h33);
        d0 = done_cnt;
        pulse_rd();
        repeat (10) @(negedge clk);
        wr_start = 1'b1; wr_data = 16'hFFFF;
        @(negedge clk); wr_start = 1'b0;
        #2;
        wait_ss_high(n_low, ones);
        chk("busy_wr_mosi_ones", ones, 32'd0);
        repeat (4) @(negedge clk);
        #2;
        chk("busy_wr_no_done", done_cnt - d0, 32'd0);
        chk("busy_wr_idle_after", {31'd0, busy}, 32'd0);
        chk("busy_wr_queue_drained", exp_q.size(), 32'd0);

        // Simultaneous rd_start and wr_start: read wins, write dropped.
        load_slave(8'h5A, 8'h04, 8'h00, 8'd2);
        exp_q.push_back(8'h5A);
        d0 = done_cnt;
        @(negedge clk); rd_start = 1'b1; wr_start = 1'b1; wr_data = 16'hBEEF;
        @(negedge clk); rd_start = 1'b0; wr_start = 1'b0;
        #2;
        wait_ss_high(n_low, ones);
        chk("both_start_ss_low_cycles", n_low, 32'd69);
        repeat (4) @(negedge clk);
        #2;
        chk("both_start_no_done", done_cnt - d0, 32'd0);
        chk("both_start_rx_count", {16'd0, rx_count}, 32'd1);
        chk("both_start_queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    join
  end

endmodule
